pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined successor to the combinational main decoder: decodes the ID-stage opcode, carries the control bundle through ID/EX, EX/MEM and MEM/WB control latches, and owns hazard control for the 5-stage MIPS core. Detects load-use hazards (stall plus bubble) and resolves taken branches and jumps (flush), and keeps saturating stall/flush event counters for debug. Sits beside the datapath pipeline registers; the forwarding unit consumes its EX/MEM and MEM/WB regwrite outputs.

## Interface
- OPCODE_W, 6, opcode field width
- RADDR_W, 5, register address width
- CNT_W, 16, width of stall/flush event counters
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- id_opcode  in  OPCODE_W  opcode of the instruction in IF/ID
- id_rs, id_rt  in  RADDR_W  source register fields in IF/ID
- mem_zero  in  1  ALU zero flag latched in EX/MEM
- pc_write  out  1  PC load enable (0 = hold)
- ifid_write  out  1  IF/ID load enable (0 = hold)
- ifid_flush  out  1  zero IF/ID on next edge
- pc_src_branch  out  1  select branch target (taken beq in MEM)
- pc_src_jump  out  1  select jump target (j in ID)
- ex_regdst, ex_alusrc, ex_memread  out  1 each  ID/EX control
- ex_aluop  out  2  ID/EX ALUOp
- ex_rt  out  RADDR_W  registered rt of the ID/EX instruction
- mem_memread, mem_memwrite, mem_branch  out  1 each  EX/MEM control
- mem_regwrite, wb_regwrite, wb_memtoreg  out  1 each  EX/MEM and MEM/WB write-back control
- illegal_op  out  1  one-cycle registered pulse for an undecodable opcode
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Decode (ID, combinational): R-type 000000 → regdst, regwrite, aluop=10, uses rs+rt. lw 100011 → alusrc, memread, memtoreg, regwrite, aluop=00, uses rs. sw 101011 → alusrc, memwrite, aluop=00, uses rs+rt. beq 000100 → branch, aluop=01, uses rs+rt. addi 001000 → alusrc, regwrite, aluop=00, uses rs. j 000010 → jump only, uses neither. Any other opcode → all-zero bundle (NOP), uses neither; illegal_op pulses the next cycle.
- Load-use stall: stall = ex_memread & (ex_rt != 0) & ((uses_rs & ex_rt==id_rs) | (uses_rt & ex_rt==id_rt)). On stall: pc_write=0, ifid_write=0, ID/EX control loads all-zero (bubble), stall_cnt++.
- Branch: taken = mem_branch & mem_zero. On taken: pc_src_branch=1, ifid_flush=1, next-edge ID/EX and EX/MEM control load zero (squashes the 3 younger instructions), flush_cnt++.
- Jump: decoded jump in ID with no taken branch → pc_src_jump=1, ifid_flush=1, flush_cnt++; the jump enters ID/EX as NOP.
- Priority: taken branch > stall > jump. A taken branch overrides a simultaneous stall (pc_write=1, ifid_write=1, no stall_cnt increment) and suppresses pc_src_jump.
- Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- All pipeline control latches advance every clock; there is no global enable and a stall only bubbles ID/EX.
- Hazard outputs (pc_write, ifid_write, ifid_flush, pc_src_*) are combinational from the current latch state and ID fields and are valid in the same cycle.
- Load-use costs exactly 1 bubble; a taken branch costs 3 squashed slots; a jump costs 1.
- Reset (rst_n=0 at an edge): all latched controls, ex_rt, illegal_op and both counters become 0. pc_write=1, ifid_write=1, and flush/pc_src outputs are 0 after reset. Reset mid-stall or mid-flush discards it with no residual effect.
- Reset has priority over stall/flush on the same edge.

## Structure
- Package ctrl_pkg: opcode constants, ALUOp encodings, ctrl_bundle_t struct (regdst, alusrc, aluop, memread, memwrite, branch, jump, regwrite, memtoreg, uses_rs, uses_rt).
- Sub-module ctrl_decoder: pure combinational opcode→ctrl_bundle_t plus illegal flag; the top holds latches, hazard logic and counters.

## Test plan
- Reset: hold rst_n=0 two cycles with lw in ID → all latched outputs 0, pc_write=1, counters 0.
- Load-use: lw $2 in EX (ex_rt=2), add with rs=2 in ID → pc_write=0, ifid_write=0, next ex_* all 0, stall_cnt=1. Repeat with ex_rt=0 → no stall.
- Taken beq: beq reaches MEM with mem_zero=1 → pc_src_branch=1, ifid_flush=1, next edge ex_memread=0 and mem_regwrite=0, flush_cnt=1. With mem_zero=0 → no flush.
- Collision: taken branch in the same cycle as a load-use hazard → pc_write=1, stall_cnt unchanged, flush_cnt+1.
- Jump and illegal: j in ID → pc_src_jump=1, ifid_flush=1. Opcode 111111 → NOP bundle, illegal_op=1 for exactly one cycle.
- Saturation: with CNT_W=2, force 5 stalls → stall_cnt stays at 3.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Control-path types for the 5-stage MIPS core:
// opcodes, ALUOp codes, decoded bundle and per-stage latches.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_e;

  typedef struct packed {
    logic   regdst;
    logic   alusrc;
    aluop_e aluop;
    logic   memread;
    logic   memwrite;
    logic   branch;
    logic   jump;
    logic   regwrite;
    logic   memtoreg;
    logic   uses_rs;
    logic   uses_rt;
  } ctrl_bundle_t;

  typedef struct packed {
    logic   regdst;
    logic   alusrc;
    aluop_e aluop;
    logic   memread;
    logic   memwrite;
    logic   branch;
    logic   regwrite;
    logic   memtoreg;
  } ex_ctrl_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
    logic branch;
    logic regwrite;
    logic memtoreg;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  function automatic ex_ctrl_t to_ex(ctrl_bundle_t c);
    ex_ctrl_t e;
    e.regdst   = c.regdst;
    e.alusrc   = c.alusrc;
    e.aluop    = c.aluop;
    e.memread  = c.memread;
    e.memwrite = c.memwrite;
    e.branch   = c.branch;
    e.regwrite = c.regwrite;
    e.memtoreg = c.memtoreg;
    return e;
  endfunction

  function automatic mem_ctrl_t to_mem(ex_ctrl_t e);
    mem_ctrl_t m;
    m.memread  = e.memread;
    m.memwrite = e.memwrite;
    m.branch   = e.branch;
    m.regwrite = e.regwrite;
    m.memtoreg = e.memtoreg;
    return m;
  endfunction

  function automatic wb_ctrl_t to_wb(mem_ctrl_t m);
    wb_ctrl_t w;
    w.regwrite = m.regwrite;
    w.memtoreg = m.memtoreg;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Main decoder: ID opcode to control bundle.
// Unknown opcodes yield a NOP bundle and raise illegal.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_bundle_t        ctrl,
  output logic                illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALU_FUNCT;
        ctrl.uses_rs  = 1'b1;
        ctrl.uses_rt  = 1'b1;
      end
      (opcode == OP_LW): begin
        ctrl.alusrc   = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.uses_rs  = 1'b1;
      end
      (opcode == OP_SW): begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.uses_rs  = 1'b1;
        ctrl.uses_rt  = 1'b1;
      end
      (opcode == OP_BEQ): begin
        ctrl.branch  = 1'b1;
        ctrl.aluop   = ALU_SUB;
        ctrl.uses_rs = 1'b1;
        ctrl.uses_rt = 1'b1;
      end
      (opcode == OP_ADDI): begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.uses_rs  = 1'b1;
      end
      (opcode == OP_J): begin
        ctrl.jump = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control: decode, ID/EX..MEM/WB control latches,
// load-use stall, branch/jump flush and debug event counters.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int RADDR_W  = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [RADDR_W-1:0]  id_rs,
  input  logic [RADDR_W-1:0]  id_rt,
  input  logic                mem_zero,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                ifid_flush,
  output logic                pc_src_branch,
  output logic                pc_src_jump,
  output logic                ex_regdst,
  output logic                ex_alusrc,
  output logic                ex_memread,
  output logic [1:0]          ex_aluop,
  output logic [RADDR_W-1:0]  ex_rt,
  output logic                mem_memread,
  output logic                mem_memwrite,
  output logic                mem_branch,
  output logic                mem_regwrite,
  output logic                wb_regwrite,
  output logic                wb_memtoreg,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  ctrl_bundle_t id_c;
  logic         id_ill;
  ex_ctrl_t     idex;
  mem_ctrl_t    exmem;
  wb_ctrl_t     memwb;

  logic taken, hit, stall, stall_go, jump_go, bubble;

  ctrl_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode  (id_opcode),
    .ctrl    (id_c),
    .illegal (id_ill)
  );

  always_comb begin
    taken    = exmem.branch & mem_zero;
    hit      = (id_c.uses_rs & (ex_rt == id_rs))
             | (id_c.uses_rt & (ex_rt == id_rt));
    stall    = idex.memread & (ex_rt != '0) & hit;
    stall_go = stall & ~taken;
    jump_go  = id_c.jump & ~taken & ~stall;
    // jump itself never reaches EX: the PC redirect is its only effect
    bubble   = taken | stall | id_c.jump;
  end

  assign pc_write      = ~stall_go;
  assign ifid_write    = ~stall_go;
  assign ifid_flush    = taken | jump_go;
  assign pc_src_branch = taken;
  assign pc_src_jump   = jump_go;

  assign ex_regdst    = idex.regdst;
  assign ex_alusrc    = idex.alusrc;
  assign ex_memread   = idex.memread;
  assign ex_aluop     = idex.aluop;
  assign mem_memread  = exmem.memread;
  assign mem_memwrite = exmem.memwrite;
  assign mem_branch   = exmem.branch;
  assign mem_regwrite = exmem.regwrite;
  assign wb_regwrite  = memwb.regwrite;
  assign wb_memtoreg  = memwb.memtoreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex       <= '0;
      ex_rt      <= '0;
      exmem      <= '0;
      memwb      <= '0;
      illegal_op <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      idex       <= bubble ? '0 : to_ex(id_c);
      ex_rt      <= bubble ? '0 : id_rt;
      exmem      <= taken ? '0 : to_mem(idex);
      memwb      <= to_wb(exmem);
      illegal_op <= id_ill;
      if (stall_go && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if ((taken || jump_go) && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Randomized bench for pipe_ctrl_unit against an
// instruction-level pipeline model.
module tb_pipe_ctrl_unit;

  localparam int R_OP = 0, LW = 35, SW = 43;
  localparam int BEQ = 4, ADDI = 8, J = 2, BUB = -1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] id_opcode = '0;
  logic [4:0] id_rs = '0, id_rt = '0;
  logic       mem_zero = 1'b0;

  logic pc_write, ifid_write, ifid_flush;
  logic pc_src_branch, pc_src_jump;
  logic ex_regdst, ex_alusrc, ex_memread;
  logic [1:0] ex_aluop;
  logic [4:0] ex_rt;
  logic mem_memread, mem_memwrite, mem_branch;
  logic mem_regwrite, wb_regwrite, wb_memtoreg, illegal_op;
  logic [15:0] stall_cnt, flush_cnt;

  logic b_pcw, b_ifw, b_iff, b_psb, b_psj;
  logic b_rd, b_as, b_mr;
  logic [1:0] b_aop;
  logic [4:0] b_rt;
  logic b_mmr, b_mmw, b_mb, b_mrw, b_wrw, b_wmt, b_ill;
  logic [1:0] s_cnt2, f_cnt2;

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .mem_zero(mem_zero),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .pc_src_branch(pc_src_branch),
    .pc_src_jump(pc_src_jump), .ex_regdst(ex_regdst),
    .ex_alusrc(ex_alusrc), .ex_memread(ex_memread),
    .ex_aluop(ex_aluop), .ex_rt(ex_rt),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_branch(mem_branch), .mem_regwrite(mem_regwrite),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .illegal_op(illegal_op), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  pipe_ctrl_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .mem_zero(mem_zero),
    .pc_write(b_pcw), .ifid_write(b_ifw),
    .ifid_flush(b_iff), .pc_src_branch(b_psb),
    .pc_src_jump(b_psj), .ex_regdst(b_rd),
    .ex_alusrc(b_as), .ex_memread(b_mr),
    .ex_aluop(b_aop), .ex_rt(b_rt),
    .mem_memread(b_mmr), .mem_memwrite(b_mmw),
    .mem_branch(b_mb), .mem_regwrite(b_mrw),
    .wb_regwrite(b_wrw), .wb_memtoreg(b_wmt),
    .illegal_op(b_ill), .stall_cnt(s_cnt2),
    .flush_cnt(f_cnt2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // model: which instruction occupies each stage
  int m_ex = BUB, m_mem = BUB, m_wb = BUB;
  int m_ext = 0;
  bit m_ill = 0;
  int m_sc = 0, m_fc = 0, m_sc2 = 0, m_fc2 = 0;

  function automatic bit legal(int op);
    return op == R_OP || op == LW || op == SW ||
           op == BEQ || op == ADDI || op == J;
  endfunction
  function automatic bit writes(int op);
    return op == R_OP || op == LW || op == ADDI;
  endfunction
  function automatic bit reads_rs(int op);
    return op == R_OP || op == LW || op == SW ||
           op == BEQ || op == ADDI;
  endfunction
  function automatic bit reads_rt(int op);
    return op == R_OP || op == SW || op == BEQ;
  endfunction
  function automatic int aluop(int op);
    if (op == R_OP) return 2;
    if (op == BEQ) return 1;
    return 0;
  endfunction
  function automatic int sat(int v, int mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  task automatic step(input int op, input int rs,
                      input int rt, input bit z,
                      input bit rn);
    bit taken, stall, jmp;
    @(negedge clk);
    id_opcode = op[5:0];
    id_rs = rs[4:0];
    id_rt = rt[4:0];
    mem_zero = z;
    rst_n = rn;
    #1;
    check("ex_regdst", ex_regdst, m_ex == R_OP);
    check("ex_alusrc", ex_alusrc,
          m_ex == LW || m_ex == SW || m_ex == ADDI);
    check("ex_memread", ex_memread, m_ex == LW);
    check("ex_aluop", ex_aluop, aluop(m_ex));
    check("ex_rt", ex_rt, m_ext);
    check("mem_memread", mem_memread, m_mem == LW);
    check("mem_memwrite", mem_memwrite, m_mem == SW);
    check("mem_branch", mem_branch, m_mem == BEQ);
    check("mem_regwrite", mem_regwrite, writes(m_mem));
    check("wb_regwrite", wb_regwrite, writes(m_wb));
    check("wb_memtoreg", wb_memtoreg, m_wb == LW);
    check("illegal_op", illegal_op, m_ill);
    check("stall_cnt", stall_cnt, m_sc);
    check("flush_cnt", flush_cnt, m_fc);
    check("stall_cnt2", s_cnt2, m_sc2);
    check("flush_cnt2", f_cnt2, m_fc2);

    taken = (m_mem == BEQ) && z;
    stall = (m_ex == LW) && m_ext != 0 &&
            ((reads_rs(op) && m_ext == rs) ||
             (reads_rt(op) && m_ext == rt));
    jmp = (op == J) && !taken && !stall;
    check("pc_write", pc_write, !(stall && !taken));
    check("ifid_write", ifid_write, !(stall && !taken));
    check("ifid_flush", ifid_flush, taken || jmp);
    check("pc_src_branch", pc_src_branch, taken);
    check("pc_src_jump", pc_src_jump, jmp);

    @(posedge clk);
    if (!rn) begin
      m_ex = BUB; m_mem = BUB; m_wb = BUB;
      m_ext = 0; m_ill = 0;
      m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    end else begin
      m_wb = m_mem;
      m_mem = taken ? BUB : m_ex;
      if (taken || stall || op == J) begin
        m_ex = BUB;
        m_ext = 0;
      end else begin
        m_ex = legal(op) ? op : BUB;
        m_ext = rt;
      end
      m_ill = !legal(op);
      if (stall && !taken) begin
        m_sc = sat(m_sc, 65535);
        m_sc2 = sat(m_sc2, 3);
      end
      if (taken || jmp) begin
        m_fc = sat(m_fc, 65535);
        m_fc2 = sat(m_fc2, 3);
      end
    end
  endtask

  function automatic int rand_op();
    case ($urandom_range(0, 8))
      0: return R_OP;
      1, 2: return LW;
      3: return SW;
      4, 5: return BEQ;
      6: return ADDI;
      7: return J;
      default: return int'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    step(LW, 1, 2, 0, 0);
    step(LW, 1, 2, 0, 0);
    // load-use, then no hazard on $0
    step(LW, 1, 2, 0, 1);
    step(R_OP, 2, 3, 0, 1);
    step(R_OP, 2, 3, 0, 1);
    step(LW, 1, 0, 0, 1);
    step(R_OP, 0, 0, 0, 1);
    // beq taken, then not taken
    step(BEQ, 1, 1, 0, 1);
    step(ADDI, 3, 4, 0, 1);
    step(LW, 3, 5, 1, 1);
    step(BEQ, 1, 1, 0, 1);
    step(ADDI, 3, 4, 0, 1);
    step(LW, 3, 5, 0, 1);
    // branch collides with load-use
    step(BEQ, 1, 1, 0, 1);
    step(LW, 1, 2, 0, 1);
    step(R_OP, 2, 3, 1, 1);
    // jump and illegal opcode
    step(J, 0, 0, 0, 1);
    step(63, 0, 0, 0, 1);
    step(R_OP, 1, 1, 0, 1);
    step(R_OP, 1, 1, 0, 1);
    // drive stall counter past saturation of the narrow copy
    repeat (5) begin
      step(LW, 0, 2, 0, 1);
      step(R_OP, 2, 0, 0, 1);
    end
    repeat (1500) begin
      step(rand_op(), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 59) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
